// File: rtl/pc_sequencer.sv
// pc_sequencer: Moore fetch/decode/execute control FSM for the adding-machine CPU.
module pc_sequencer #(
  parameter int ADDR_W = 6,
  parameter int CNT_W = 8,
  parameter logic [ADDR_W-1:0] HLT_ADDR = 6'h3F
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic pause,
  input  logic [ADDR_W+1:0] ir,
  output logic clr_pc,
  output logic inc_pc,
  output logic ld_pc,
  output logic ld_ar,
  output logic ar_sel,
  output logic mem_rd,
  output logic ld_ir,
  output logic ld_dr,
  output logic ld_ac,
  output logic alu_op,
  output logic clr_ac,
  output logic inc_ac,
  output logic busy,
  output logic halted,
  output logic [CNT_W-1:0] instr_cnt
);
  typedef enum logic [3:0] {IDLE, INIT, F0, F1, F2, DEC, M0, M1, M2, EA, EJ, EI, PAUSE, HALT} state_t;
  state_t state, nxt;
  logic alu_q, retire;
  logic [1:0] op;
  assign op = ir[ADDR_W+1:ADDR_W];
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:        nxt = start ? INIT : IDLE;
      INIT:        nxt = F0;
      F0:          nxt = F1;
      F1:          nxt = F2;
      F2:          nxt = DEC;
      DEC:         nxt = !op[1] ? M0 : !op[0] ? EJ : (ir[ADDR_W-1:0] == HLT_ADDR) ? HALT : EI;
      M0:          nxt = M1;
      M1:          nxt = M2;
      M2:          nxt = EA;
      EA, EJ, EI:  nxt = pause ? PAUSE : F0;
      PAUSE:       nxt = pause ? PAUSE : F0;
      HALT:        nxt = start ? INIT : HALT;
      default:     nxt = IDLE;
    endcase
  end
  assign retire = (state == EA) || (state == EJ) || (state == EI) || (state == DEC && nxt == HALT);
  // Outputs are registered from the next state, so each one is a clean decode of the state it belongs to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      alu_q <= 1'b0;
      instr_cnt <= '0;
      {clr_pc, inc_pc, ld_pc, ld_ar, ar_sel, mem_rd, ld_ir} <= '0;
      {ld_dr, ld_ac, alu_op, clr_ac, inc_ac, busy, halted} <= '0;
    end else begin
      state <= nxt;
      if (state == DEC) alu_q <= op[0];
      instr_cnt <= (state == INIT) ? '0 : (retire && instr_cnt != '1) ? instr_cnt + 1'b1 : instr_cnt;
      clr_pc <= nxt == INIT;
      clr_ac <= nxt == INIT;
      inc_pc <= nxt == F1;
      ld_pc <= nxt == EJ;
      ld_ar <= (nxt == F0) || (nxt == M0);
      ar_sel <= nxt == M0;
      mem_rd <= (nxt == F1) || (nxt == M1);
      ld_ir <= nxt == F2;
      ld_dr <= nxt == M2;
      ld_ac <= nxt == EA;
      alu_op <= (nxt == EA) && alu_q;
      inc_ac <= nxt == EI;
      busy <= !((nxt == IDLE) || (nxt == HALT) || (nxt == PAUSE));
      halted <= nxt == HALT;
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: drives pc_sequencer with a datapath/memory model and checks it against an ISA-level interpreter.
module tb_pc_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, pause = 1'b0;
  logic [7:0] ir = '0;
  logic clr_pc, inc_pc, ld_pc, ld_ar, ar_sel, mem_rd, ld_ir, ld_dr, ld_ac, alu_op, clr_ac, inc_ac, busy, halted;
  logic [7:0] instr_cnt;
  logic [13:0] outs;
  int checks = 0, errors = 0;

  logic [7:0] mem [64];
  logic [5:0] pc = '0, ar = '0;
  logic [7:0] mem_dout = '0, dr = '0, ac = '0;

  always #5 clk = ~clk;

  pc_sequencer #(.ADDR_W(6), .CNT_W(8), .HLT_ADDR(6'h3F)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .ir(ir),
    .clr_pc(clr_pc), .inc_pc(inc_pc), .ld_pc(ld_pc), .ld_ar(ld_ar), .ar_sel(ar_sel),
    .mem_rd(mem_rd), .ld_ir(ld_ir), .ld_dr(ld_dr), .ld_ac(ld_ac), .alu_op(alu_op),
    .clr_ac(clr_ac), .inc_ac(inc_ac), .busy(busy), .halted(halted), .instr_cnt(instr_cnt)
  );

  assign outs = {clr_pc, inc_pc, ld_pc, ld_ar, ar_sel, mem_rd, ld_ir, ld_dr, ld_ac, alu_op, clr_ac, inc_ac, busy, halted};

  // Phase-1 datapath: PC, AR, synchronous memory, IR, DR and AC responding to the strobes.
  always @(posedge clk) begin
    if (clr_pc) pc <= '0;
    else if (inc_pc) pc <= pc + 6'd1;
    else if (ld_pc) pc <= ir[5:0];
    if (ld_ar) ar <= ar_sel ? ir[5:0] : pc;
    if (mem_rd) mem_dout <= mem[ar];
    if (ld_ir) ir <= mem_dout;
    if (ld_dr) dr <= mem_dout;
    if (clr_ac) ac <= '0;
    else if (inc_ac) ac <= ac + 8'd1;
    else if (ld_ac) ac <= alu_op ? (ac & dr) : (ac + dr);
  end

  // Instruction-level interpreter: per-instruction cycle costs, AC result, retire count, final PC.
  function automatic void model(output logic [7:0] m_ac, output int m_cnt, output int m_cyc,
                                output logic [5:0] m_pc, output int n_add, output int n_and,
                                output int n_inc, output int n_jmp);
    logic [5:0] p;
    logic [7:0] w;
    p = '0; m_ac = '0; m_cnt = 0; m_cyc = 1; n_add = 0; n_and = 0; n_inc = 0; n_jmp = 0;
    for (int k = 0; k < 1000; k++) begin
      w = mem[p];
      p = p + 6'd1;
      m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      if (w == 8'hFF) begin m_cyc += 4; break; end
      case (w[7:6])
        2'b00: begin m_ac = m_ac + mem[w[5:0]]; m_cyc += 8; n_add++; end
        2'b01: begin m_ac = m_ac & mem[w[5:0]]; m_cyc += 8; n_and++; end
        2'b10: begin p = w[5:0]; m_cyc += 5; n_jmp++; end
        default: begin m_ac = m_ac + 8'd1; m_cyc += 5; n_inc++; end
      endcase
    end
    m_pc = p;
  endfunction

  task automatic clear_mem;
    for (int a = 0; a < 64; a++) mem[a] = '0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_prog(output int cyc, output int n_l0, output int n_l1, output int n_inc,
                          output int n_pc, output int n_rd, output int viol, output int idx_ac,
                          output int idx_pc);
    int i;
    n_l0 = 0; n_l1 = 0; n_inc = 0; n_pc = 0; n_rd = 0; viol = 0; idx_ac = -1; idx_pc = -1;
    pulse_start();
    i = 0;
    while (!halted && i < 3000) begin
      if (ld_ac) begin
        if (alu_op) n_l1++; else n_l0++;
        if (idx_ac < 0) idx_ac = i;
      end
      if (inc_ac) n_inc++;
      if (ld_pc) begin n_pc++; idx_pc = i; end
      if (mem_rd) n_rd++;
      if (int'(clr_pc) + int'(inc_pc) + int'(ld_pc) > 1 || (ld_ar && mem_rd) || !busy) viol++;
      @(negedge clk);
      i++;
    end
    cyc = i;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (outs !== 14'd0) begin errors++; $display("FAIL reset_outs: got %b exp 0", outs); end
    checks++; if (instr_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", instr_cnt); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (outs !== 14'd0) begin errors++; $display("FAIL idle_outs: got %b exp 0", outs); end
  endtask

  task automatic test_add_hlt;
    int cyc, l0, l1, ni, np, nr, v, ia, ip;
    clear_mem();
    mem[0] = 8'h04; mem[1] = 8'hFF; mem[4] = 8'h05;
    run_prog(cyc, l0, l1, ni, np, nr, v, ia, ip);
    checks++; if (cyc !== 13) begin errors++; $display("FAIL add_cycles: got %0d exp 13", cyc); end
    checks++; if (ia !== 8 || l0 !== 1 || l1 !== 0) begin errors++; $display("FAIL add_ldac: idx %0d add %0d and %0d exp 8 1 0", ia, l0, l1); end
    checks++; if (nr !== 3) begin errors++; $display("FAIL add_memrd: got %0d exp 3", nr); end
    checks++; if (ac !== 8'h05) begin errors++; $display("FAIL add_ac: got %h exp 05", ac); end
    checks++; if (instr_cnt !== 8'd2 || halted !== 1'b1) begin errors++; $display("FAIL add_cnt: cnt %0d halted %b exp 2 1", instr_cnt, halted); end
    checks++; if (v !== 0) begin errors++; $display("FAIL add_invariant: got %0d exp 0", v); end
  endtask

  task automatic test_opcodes;
    int cyc, l0, l1, ni, np, nr, v, ia, ip;
    clear_mem();
    mem[0] = 8'h45; mem[1] = 8'hC0; mem[2] = 8'h83; mem[3] = 8'hFF; mem[5] = 8'h3C;
    run_prog(cyc, l0, l1, ni, np, nr, v, ia, ip);
    checks++; if (cyc !== 23) begin errors++; $display("FAIL ops_cycles: got %0d exp 23", cyc); end
    checks++; if (l1 !== 1 || l0 !== 0) begin errors++; $display("FAIL ops_aluop: and %0d add %0d exp 1 0", l1, l0); end
    checks++; if (ni !== 1) begin errors++; $display("FAIL ops_inc: got %0d exp 1", ni); end
    checks++; if (np !== 1 || ip !== 18) begin errors++; $display("FAIL ops_ldpc: n %0d idx %0d exp 1 18", np, ip); end
    checks++; if (instr_cnt !== 8'd4 || ac !== 8'h01) begin errors++; $display("FAIL ops_result: cnt %0d ac %h exp 4 01", instr_cnt, ac); end
  endtask

  task automatic test_pause;
    int i, bad;
    clear_mem();
    mem[0] = 8'h04; mem[1] = 8'hC0; mem[2] = 8'hFF; mem[4] = 8'h05;
    pulse_start();
    i = 0;
    while (!(ld_ar && ar_sel) && i < 50) begin @(negedge clk); i++; end
    pause = 1'b1;
    while (!ld_ac && i < 50) begin @(negedge clk); i++; end
    checks++; if (!ld_ac || alu_op !== 1'b0) begin errors++; $display("FAIL pause_ea: ld_ac %b alu_op %b exp 1 0", ld_ac, alu_op); end
    @(negedge clk);
    checks++; if (instr_cnt !== 8'd1) begin errors++; $display("FAIL pause_cnt: got %0d exp 1", instr_cnt); end
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (outs !== 14'd0) bad++;
      start = (k == 4);
      @(negedge clk);
    end
    start = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL pause_hold: got %0d active cycles exp 0", bad); end
    pause = 1'b0;
    @(negedge clk);
    checks++; if (!(ld_ar && !ar_sel && busy)) begin errors++; $display("FAIL pause_resume: ld_ar %b ar_sel %b busy %b exp 1 0 1", ld_ar, ar_sel, busy); end
    i = 0;
    while (!halted && i < 100) begin @(negedge clk); i++; end
    checks++; if (!halted || instr_cnt !== 8'd3 || ac !== 8'h06) begin errors++; $display("FAIL pause_final: halted %b cnt %0d ac %h exp 1 3 06", halted, instr_cnt, ac); end
  endtask

  task automatic test_restart;
    int i;
    checks++; if (halted !== 1'b1 || instr_cnt !== 8'd3) begin errors++; $display("FAIL restart_pre: halted %b cnt %0d exp 1 3", halted, instr_cnt); end
    pulse_start();
    checks++; if (!(clr_pc && clr_ac && busy && !halted)) begin errors++; $display("FAIL restart_init: outs %b", outs); end
    @(negedge clk);
    checks++; if (instr_cnt !== 8'd0 || pc !== 6'd0 || !(ld_ar && !ar_sel)) begin errors++; $display("FAIL restart_f0: cnt %0d pc %0d ld_ar %b exp 0 0 1", instr_cnt, pc, ld_ar); end
    i = 0;
    while (!halted && i < 100) begin @(negedge clk); i++; end
    checks++; if (!halted || instr_cnt !== 8'd3) begin errors++; $display("FAIL restart_final: halted %b cnt %0d exp 1 3", halted, instr_cnt); end
  endtask

  task automatic test_random;
    int cyc, l0, l1, ni, np, nr, v, ia, ip, n, op, m_cnt, m_cyc, n_add, n_and, n_inc, n_jmp;
    logic [7:0] m_ac;
    logic [5:0] m_pc;
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(3, 20);
      for (int a = 0; a < 64; a++) mem[a] = 8'($urandom);
      for (int k = 0; k < n; k++) begin
        op = $urandom_range(0, 3);
        if (op == 2) mem[k] = {2'b10, 6'($urandom_range(k + 1, n))};
        else if (op == 3) mem[k] = {2'b11, 6'($urandom_range(0, 62))};
        else mem[k] = {2'(op), 6'($urandom_range(0, 63))};
      end
      mem[n] = 8'hFF;
      model(m_ac, m_cnt, m_cyc, m_pc, n_add, n_and, n_inc, n_jmp);
      run_prog(cyc, l0, l1, ni, np, nr, v, ia, ip);
      checks++; if (cyc !== m_cyc) begin errors++; $display("FAIL rnd%0d_cycles: got %0d exp %0d", t, cyc, m_cyc); end
      checks++; if (ac !== m_ac) begin errors++; $display("FAIL rnd%0d_ac: got %h exp %h", t, ac, m_ac); end
      checks++; if (int'(instr_cnt) !== m_cnt) begin errors++; $display("FAIL rnd%0d_cnt: got %0d exp %0d", t, instr_cnt, m_cnt); end
      checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd%0d_pc: got %0d exp %0d", t, pc, m_pc); end
      checks++; if (l0 !== n_add || l1 !== n_and || ni !== n_inc || np !== n_jmp) begin errors++; $display("FAIL rnd%0d_strobes: add %0d and %0d inc %0d jmp %0d exp %0d %0d %0d %0d", t, l0, l1, ni, np, n_add, n_and, n_inc, n_jmp); end
      checks++; if (v !== 0) begin errors++; $display("FAIL rnd%0d_invariant: got %0d exp 0", t, v); end
    end
  endtask

  task automatic test_reset_mid;
    int i, seen, bad;
    clear_mem();
    mem[0] = 8'h04; mem[1] = 8'h04; mem[2] = 8'hFF; mem[4] = 8'h07;
    pulse_start();
    i = 0; seen = 0;
    while (seen < 2 && i < 100) begin
      @(negedge clk);
      i++;
      if (mem_rd && !inc_pc) seen++;
    end
    checks++; if (seen !== 2 || instr_cnt !== 8'd1) begin errors++; $display("FAIL mid_reach_m1: seen %0d cnt %0d exp 2 1", seen, instr_cnt); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (outs !== 14'd0 || instr_cnt !== 8'd0) begin errors++; $display("FAIL mid_reset: outs %b cnt %0d exp 0 0", outs, instr_cnt); end
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (outs !== 14'd0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL mid_stay_idle: got %0d active cycles exp 0", bad); end
  endtask

  task automatic test_saturation;
    int v, max_cnt;
    clear_mem();
    mem[0] = 8'h80;
    pulse_start();
    v = 0; max_cnt = 0;
    for (int k = 0; k < 2000; k++) begin
      if (int'(clr_pc) + int'(inc_pc) + int'(ld_pc) > 1 || (ld_ar && mem_rd)) v++;
      if (int'(instr_cnt) > max_cnt) max_cnt = int'(instr_cnt);
      @(negedge clk);
    end
    checks++; if (instr_cnt !== 8'd255 || max_cnt !== 255) begin errors++; $display("FAIL sat_cnt: got %0d max %0d exp 255", instr_cnt, max_cnt); end
    checks++; if (v !== 0) begin errors++; $display("FAIL sat_invariant: got %0d exp 0", v); end
    checks++; if (busy !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL sat_running: busy %b halted %b exp 1 0", busy, halted); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_add_hlt();
    test_opcodes();
    test_pause();
    test_restart();
    test_random();
    test_reset_mid();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
